// File: rtl/popcount_vec_sched_pkg.sv
// popcount_vec_sched_pkg: scheduler state encoding and byte width shared by the popcount schedulers
package popcount_vec_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/popcount_int8.sv
// popcount_int8: combinational 8-bit population count
module popcount_int8 #(
  parameter int IMPL_TYPE = 0
) (
  input  logic [7:0] a,
  output logic [3:0] y
);
  if (IMPL_TYPE == 0) begin : g_tree
    logic [1:0] s2 [4];
    logic [2:0] s4 [2];
    for (genvar i = 0; i < 4; i++) begin : g_s2
      assign s2[i] = {1'b0, a[2*i]} + {1'b0, a[2*i+1]};
    end
    for (genvar j = 0; j < 2; j++) begin : g_s4
      assign s4[j] = {1'b0, s2[2*j]} + {1'b0, s2[2*j+1]};
    end
    assign y = {1'b0, s4[0]} + {1'b0, s4[1]};
  end else begin : g_loop
    always_comb begin
      y = '0;
      for (int i = 0; i < 8; i++) y = y + {3'b0, a[i]};
    end
  end
endmodule

// File: rtl/popcount_vec_sched.sv
// popcount_vec_sched: one byte per clock through a shared popcount_int8, summing a vector's bit count
module popcount_vec_sched
  import popcount_vec_sched_pkg::*;
#(
  parameter int NUM_BYTES = 4,
  parameter int IMPL_TYPE = 0,
  localparam int LEN_W = $clog2(NUM_BYTES + 1),
  localparam int CNT_W = $clog2(8 * NUM_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_data,
  input  logic [LEN_W-1:0]       in_len,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       out_count,
  output logic                   busy
);
  state_t                 state;
  logic [8*NUM_BYTES-1:0] sr;
  logic [LEN_W-1:0]       len, idx, len_c;
  logic [3:0]             pc_y, pc_q;
  logic                   pc_vld_q;
  logic [CNT_W-1:0]       acc;
  logic                   in_fire;
  popcount_int8 #(.IMPL_TYPE(IMPL_TYPE)) u_pc (.a(sr[BYTE_W-1:0]), .y(pc_y));
  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign out_count = acc;
  assign len_c     = (in_len == '0 || in_len > LEN_W'(NUM_BYTES)) ? LEN_W'(NUM_BYTES) : in_len;
  // The count issued on the last byte lands in acc one edge later, so DONE waits for pc_vld_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      len      <= '0;
      idx      <= '0;
      pc_q     <= '0;
      pc_vld_q <= 1'b0;
      acc      <= '0;
    end else if (in_fire) begin
      state    <= RUN;
      sr       <= in_data;
      len      <= len_c;
      idx      <= '0;
      acc      <= '0;
      pc_vld_q <= 1'b0;
    end else begin
      if (pc_vld_q) acc <= acc + CNT_W'(pc_q);
      if (state == RUN) begin
        if (idx < len) begin
          pc_q     <= pc_y;
          pc_vld_q <= 1'b1;
          sr       <= sr >> BYTE_W;
          idx      <= idx + LEN_W'(1);
        end else begin
          pc_vld_q <= 1'b0;
          if (pc_vld_q) state <= DONE;
        end
      end
      if (state == DONE && out_ready) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_popcount_vec_sched.sv
// tb_popcount_vec_sched: directed and randomized checks of the popcount scheduler at 4 and 1 bytes
module tb_popcount_vec_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_busy;
  logic [31:0] a_in_data = '0;
  logic [2:0]  a_in_len = '0;
  logic [5:0]  a_out_count;
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_busy;
  logic [7:0]  b_in_data = '0;
  logic [0:0]  b_in_len = '0;
  logic [3:0]  b_out_count;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  popcount_vec_sched #(.NUM_BYTES(4), .IMPL_TYPE(0)) dut4 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_len(a_in_len), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_count(a_out_count),
    .busy(a_busy));

  popcount_vec_sched #(.NUM_BYTES(1), .IMPL_TYPE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_len(b_in_len), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count),
    .busy(b_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Submit one job to the 4-byte DUT, scramble inputs after accept, check latency and count.
  task automatic job4(input logic [31:0] d, input logic [2:0] l, input int exp_c);
    int lat;
    lat = (l == 0 || l > 4) ? 4 : int'(l);
    a_in_valid = 1'b1; a_in_data = d; a_in_len = l; a_out_ready = 1'b0;
    step();
    a_in_valid = 1'b0; a_in_data = $urandom; a_in_len = 3'($urandom);
    chk("busy_after_accept", a_busy, 1);
    for (int k = 1; k <= lat + 1; k++) begin
      step();
      chk("latency_out_valid", a_out_valid, (k == lat + 1) ? 1 : 0);
      chk("in_ready_while_busy", a_in_ready, 0);
    end
    chk("job_count", a_out_count, exp_c);
  endtask

  task automatic release_a();
    a_out_ready = 1'b1;
    step();
    chk("release_idle", a_busy, 0);
    a_out_ready = 1'b0;
  endtask

  // Random valid/ready traffic against a job-level model: queue of expected bit counts.
  task automatic rand_run(input bit sel, input int jobs);
    int q[$];
    int nb, done, cyc, l, bad;
    bit have, rdy, ov, ordy, bz, prev_hold;
    logic [31:0] d, oc, prev_c, m;
    logic [2:0] len;
    nb = sel ? 1 : 4; done = 0; cyc = 0; bad = 0; have = 0; prev_hold = 0;
    d = '0; len = '0; prev_c = '0;
    while (done < jobs && cyc < jobs * 30) begin
      if (!have && $urandom_range(3) != 0) begin
        d = $urandom; len = 3'($urandom_range(0, sel ? 1 : 7)); have = 1;
      end
      ordy = $urandom_range(2) != 0;
      if (sel) begin
        b_in_valid = have; b_in_data = d[7:0]; b_in_len = len[0]; b_out_ready = ordy;
      end else begin
        a_in_valid = have; a_in_data = d; a_in_len = len; a_out_ready = ordy;
      end
      #1;
      rdy = sel ? b_in_ready : a_in_ready;
      ov  = sel ? b_out_valid : a_out_valid;
      bz  = sel ? b_busy : a_busy;
      oc  = sel ? 32'(b_out_count) : 32'(a_out_count);
      if (prev_hold && (!ov || oc != prev_c)) bad++;
      if (bz && !ov && rdy) bad++;
      if (ov && ordy) begin
        if (q.size() == 0) chk("spurious_out", oc, 32'hDEAD_BEEF);
        else chk(sel ? "rand_count_nb1" : "rand_count_nb4", oc, 32'(q.pop_front()));
        done++;
      end
      if (have && rdy) begin
        l = (len == 0 || int'(len) > nb) ? nb : int'(len);
        m = 32'((64'd1 << (8 * l)) - 64'd1);
        q.push_back($countones(d & m));
        have = 0;
      end
      prev_hold = ov && !ordy;
      prev_c = oc;
      cyc++;
      @(negedge clk);
    end
    chk(sel ? "rand_jobs_done_nb1" : "rand_jobs_done_nb4", done, jobs);
    chk(sel ? "rand_protocol_nb1" : "rand_protocol_nb4", bad, 0);
    a_in_valid = 1'b0; b_in_valid = 1'b0; a_out_ready = 1'b1; b_out_ready = 1'b1;
    repeat (8) step();
  endtask

  initial begin
    // 1: reset held with a pending vector
    a_in_valid = 1'b1; a_in_data = 32'hFFFF_FFFF; b_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_out_count", a_out_count, 0);
      chk("rst_busy", a_busy, 0);
    end
    chk("rst_nb1_busy", b_busy, 0);
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("post_rst_idle", a_busy, 0);
    // 2: full vector, len 0 means all bytes
    job4(32'hFFFF_FFFF, 3'd0, 32);
    release_a();
    // 3: two bytes only
    job4(32'hAAAA_0F03, 3'd2, 6);
    // 4: backpressure then same-edge handoff
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_out_valid", a_out_valid, 1);
      chk("hold_out_count", a_out_count, 6);
    end
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 32'h0000_0001; a_in_len = 3'd1;
    #1;
    chk("handoff_in_ready", a_in_ready, 1);
    step();
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    chk("handoff_out_valid_low", a_out_valid, 0);
    chk("handoff_busy", a_busy, 1);
    step();
    chk("handoff_lat1", a_out_valid, 0);
    step();
    chk("handoff_lat2", a_out_valid, 1);
    chk("handoff_count", a_out_count, 1);
    release_a();
    // 5: reset mid-job drops it
    a_in_valid = 1'b1; a_in_data = 32'hFFFF_FFFF; a_in_len = 3'd0;
    step();
    a_in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("midrst_busy", a_busy, 0);
    chk("midrst_count", a_out_count, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_no_out", a_out_valid, 0);
    end
    job4(32'h0101_0101, 3'd0, 4);
    release_a();
    // 6: single-byte configuration
    b_in_valid = 1'b1; b_in_data = 8'h80; b_in_len = 1'b1; b_out_ready = 1'b0;
    step();
    b_in_valid = 1'b0; b_in_data = 8'hFF;
    step();
    chk("nb1_lat1", b_out_valid, 0);
    step();
    chk("nb1_lat2", b_out_valid, 1);
    chk("nb1_count", b_out_count, 1);
    b_out_ready = 1'b1;
    step();
    chk("nb1_release", b_busy, 0);
    rand_run(1'b1, 1000);
    rand_run(1'b0, 300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
